// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, drives the combinational ROM and queues
// {pc, instr} in a 2-entry buffer for decode; one-cycle fetch latency, stalls while the buffer is full.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 101
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_fault
);

  typedef enum logic {RUN, FAULT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  count;
  entry_t      head;
  entry_t      tail;

  logic   pc_in_range;
  logic   redirect_ok;
  logic   pop;
  logic   push;
  entry_t fetched;

  assign pc_in_range = (pc[31:2] < WORD_LIMIT);
  assign redirect_ok = (redirect_pc[1:0] == 2'b00) && (redirect_pc[31:2] < WORD_LIMIT);
  assign pop         = out_valid && out_ready;
  assign push        = (state == RUN) && pc_in_range && ((count < 2'd2) || pop);
  assign fetched     = '{pc: pc, instr: imem_instr};

  assign imem_addr   = pc;
  assign out_valid   = (count != 2'd0);
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign fetch_fault = (state == FAULT);

  // head is the decode-facing entry; tail only ever holds the second queued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (redirect_valid) begin
      count <= 2'd0;
      pc    <= redirect_pc;
      state <= redirect_ok ? RUN : FAULT;
    end else begin
      if (state == RUN && !pc_in_range)
        state <= FAULT;
      if (push)
        pc <= pc + 32'd4;

      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= fetched;
          else               tail <= fetched;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= fetched;
          end else begin
            head <= fetched;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural ROM holding {16'hC0DE, word index}.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  imem_fetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(101)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input int unsigned idx);
    return {16'hC0DE, idx[15:0]};
  endfunction

  always_comb begin
    imem_instr = 32'hDEAD_BEEF;
    if (imem_addr[31:2] < 30'd101) imem_instr = rom(int'(imem_addr[31:2]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_pc;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    #23;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_pc",    out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    rst = 1'b0;

    // sequential fetch with decode always ready
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_valid", 32'(out_valid), 32'd1);
      chk("seq_pc",    out_pc, 32'(4 * i));
      chk("seq_instr", out_instr, rom(i));
    end

    // back-pressure from a fresh reset
    rst = 1'b1; out_ready = 1'b0; #4; rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_addr",  imem_addr, 32'h8);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_pc",    out_pc, 32'h0);
    chk("bp_instr", out_instr, rom(0));
    out_ready = 1'b1;
    step();
    chk("bp_rel_pc1", out_pc, 32'h4);
    chk("bp_rel_ad1", imem_addr, 32'hC);
    step();
    chk("bp_rel_pc2", out_pc, 32'h8);
    chk("bp_rel_in2", out_instr, rom(2));

    // redirect while full, with a pop in the same cycle
    out_ready = 1'b0;
    step();
    chk("full_pc", out_pc, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h20; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_addr",  imem_addr, 32'h20);
    step();
    chk("redir_v2",    32'(out_valid), 32'd1);
    chk("redir_pc",    out_pc, 32'h20);
    chk("redir_instr", out_instr, rom(8));

    // run off the end of the ROM
    redirect_valid = 1'b1; redirect_pc = 32'h180;
    step();
    redirect_valid = 1'b0;
    last_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 20 && !fetch_fault; i++) begin
      step();
      if (out_valid) last_pc = out_pc;
    end
    chk("end_fault",   32'(fetch_fault), 32'd1);
    chk("end_last_pc", last_pc, 32'h190);
    chk("end_valid",   32'(out_valid), 32'd0);
    chk("end_addr",    imem_addr, 32'h194);
    step(); step();
    chk("end_hold_v",  32'(out_valid), 32'd0);
    chk("end_hold_f",  32'(fetch_fault), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("recov_fault", 32'(fetch_fault), 32'd0);
    chk("recov_v0",    32'(out_valid), 32'd0);
    step();
    chk("recov_valid", 32'(out_valid), 32'd1);
    chk("recov_pc",    out_pc, 32'h0);

    // misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    step();
    redirect_valid = 1'b0;
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_valid", 32'(out_valid), 32'd0);
    chk("mis_addr",  imem_addr, 32'h22);
    step();
    chk("mis_nopush", 32'(out_valid), 32'd0);
    chk("mis_hold",   32'(fetch_fault), 32'd1);

    // async reset mid-stream with two entries buffered
    redirect_valid = 1'b1; redirect_pc = 32'h10; out_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    step(); step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_addr",  imem_addr, 32'h18);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_fault", 32'(fetch_fault), 32'd0);
    chk("arst_addr",  imem_addr, 32'h0);
    chk("arst_pc",    out_pc, 32'h0);
    #1 rst = 1'b0; out_ready = 1'b1;
    step();
    chk("post_rst_pc", out_pc, 32'h0);
    chk("post_rst_v",  32'(out_valid), 32'd1);
    step();
    chk("post_rst_pc2", out_pc, 32'h4);
    chk("post_rst_in2", out_instr, rom(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
